fc_argmax_ctrl: RTL and testbench

Initiator and collector for the fully-connected output neurons of the CNN classifier. It sequences the neurons one at a time over the enable/done handshake and captures each signed score. It then reports the index and value of the largest score. It sits after the final FC stage and drives the neuron's enable, weight/bias-set select and clear, in place of hand-wired per-neuron control.

---
 rtl/fc_argmax_ctrl.sv | 102 ++++++++++
 tb/tb_fc_argmax_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_ctrl.sv
// Sequences the FC output neurons over the enable/done handshake and tracks the
// running maximum score; reports argmax index and value with a one-cycle valid.
module fc_argmax_ctrl #(
  parameter int N_CLASS = 10,
  parameter int DW      = 38,
  parameter int IW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 fc_enable,
  output logic [IW-1:0]        fc_sel,
  input  logic signed [DW-1:0] fc_out,
  input  logic                 fc_done,
  output logic                 busy,
  output logic [IW-1:0]        class_id,
  output logic signed [DW-1:0] class_score,
  output logic                 valid
);

  // state | meaning
  // IDLE  | waiting for start
  // REQ   | neuron enabled on class idx, waiting for fc_done
  // CLR   | enable low for one cycle so the neuron clears
  // DONE  | result published, valid pulse
  typedef enum logic [1:0] {IDLE, REQ, CLR, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(N_CLASS - 1);

  state_t               state, state_nx;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        best_idx;
  logic signed [DW-1:0] best;
  logic                 last_cls;
  logic                 take;

  assign last_cls = (idx == LAST);
  // Strict compare keeps the lowest index on ties; class 0 always seeds best.
  assign take     = (state == REQ) && fc_done && ((idx == '0) || (fc_out > best));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)   state_nx = REQ;
      REQ:     if (fc_done) state_nx = CLR;
      CLR:     state_nx = last_cls ? DONE : REQ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      best_idx    <= '0;
      best        <= '0;
      class_id    <= '0;
      class_score <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            best_idx <= '0;
            best     <= '0;
          end
        end
        REQ: begin
          if (take) begin
            best     <= fc_out;
            best_idx <= idx;
          end
        end
        CLR: begin
          // Result registers load on the edge into DONE so they are already
          // current during the valid pulse.
          if (last_cls) begin
            class_id    <= best_idx;
            class_score <= best;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fc_enable = (state == REQ);
  assign fc_sel    = idx;
  assign busy      = (state != IDLE);
  assign valid     = (state == DONE);

endmodule

// File: tb/tb_fc_argmax_ctrl.sv
// Directed bench for fc_argmax_ctrl with a behavioural neuron of per-class latency.
module tb_fc_argmax_ctrl;
  localparam int N  = 10;
  localparam int DW = 38;
  localparam int IW = 4;
  localparam logic signed [DW-1:0] MINV    = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] FORCE_V = 38'sd1000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 fc_enable;
  logic [IW-1:0]        fc_sel;
  logic signed [DW-1:0] fc_out;
  logic                 fc_done;
  logic                 busy;
  logic [IW-1:0]        class_id;
  logic signed [DW-1:0] class_score;
  logic                 valid;

  fc_argmax_ctrl #(.N_CLASS(N), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .fc_enable(fc_enable), .fc_sel(fc_sel), .fc_out(fc_out), .fc_done(fc_done),
    .busy(busy), .class_id(class_id), .class_score(class_score), .valid(valid)
  );

  always #5 clk = ~clk;

  // Neuron model: done rises after lat[sel] enabled edges, clears when enable is low.
  logic signed [DW-1:0] scores [16];
  int                   lat    [16];
  int                   ncnt;
  logic                 m_done;
  logic                 force_clr;

  always @(posedge clk) begin
    if (!fc_enable) begin
      ncnt   <= 0;
      m_done <= 1'b0;
    end else if (!m_done) begin
      ncnt <= ncnt + 1;
      if (ncnt + 1 >= lat[fc_sel]) m_done <= 1'b1;
    end
  end

  assign fc_done = m_done | (force_clr & ~fc_enable & busy);
  assign fc_out  = (force_clr && !fc_enable) ? FORCE_V : scores[fc_sel];

  // Observers
  int            valid_cnt, req3, sel_chg, low_run, runs_total, runs_bad;
  logic          prev_en;
  logic [IW-1:0] prev_sel;
  logic [IW-1:0] cap_q [$];

  initial begin
    valid_cnt = 0; req3 = 0; sel_chg = 0; low_run = 0; runs_total = 0; runs_bad = 0;
    prev_en = 1'b0; prev_sel = '0;
  end

  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (fc_enable && fc_done) cap_q.push_back(fc_sel);
    if (fc_enable && fc_sel == 4'd3) req3++;
    if (fc_enable && prev_en && fc_sel != prev_sel) sel_chg++;
    if (!busy) low_run = 0;
    else if (!fc_enable) low_run++;
    else begin
      if (low_run > 0) begin
        runs_total++;
        if (low_run != 1) runs_bad++;
      end
      low_run = 0;
    end
    prev_en  = fc_enable;
    prev_sel = fc_sel;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic clear_obs();
    valid_cnt = 0; req3 = 0; sel_chg = 0; runs_total = 0; runs_bad = 0;
    cap_q.delete();
  endtask

  task automatic set_lat1();
    for (int i = 0; i < 16; i++) lat[i] = 1;
  endtask

  task automatic load_basic();
    int v [N] = '{-5, 3, 17, 2, 0, -9, 16, 1, 4, 8};
    for (int i = 0; i < 16; i++) scores[i] = '0;
    for (int i = 0; i < N; i++) scores[i] = DW'(v[i]);
  endtask

  // Start one classification and return cycles from the start edge to valid (-1 on timeout).
  task automatic run(output int lat_cyc);
    int n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (!valid && n < 1000) begin @(negedge clk); n++; end
    lat_cyc = valid ? n : -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; force_clr = 1'b0;
    set_lat1(); load_basic();
    repeat (2) @(negedge clk);
    n_chk++; if (fc_enable !== 1'b0) begin n_fail++; $display("FAIL reset_fc_enable got=%b exp=0", fc_enable); end
    n_chk++; if (fc_sel !== '0) begin n_fail++; $display("FAIL reset_fc_sel got=%0d exp=0", fc_sel); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_chk++; if (class_id !== '0) begin n_fail++; $display("FAIL reset_class_id got=%0d exp=0", class_id); end
    n_chk++; if (class_score !== '0) begin n_fail++; $display("FAIL reset_class_score got=%0d exp=0", class_score); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_wins_over_start busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int l, bad;
    set_lat1(); load_basic(); clear_obs();
    run(l);
    n_chk++; if (l != 31) begin n_fail++; $display("FAIL basic_latency got=%0d exp=31", l); end
    n_chk++; if (class_id !== 4'd2) begin n_fail++; $display("FAIL basic_class_id got=%0d exp=2", class_id); end
    n_chk++; if (class_score !== 38'sd17) begin n_fail++; $display("FAIL basic_class_score got=%0d exp=17", class_score); end
    n_chk++; if (valid_cnt != 1) begin n_fail++; $display("FAIL basic_valid_pulses got=%0d exp=1", valid_cnt); end
    bad = 0;
    foreach (cap_q[i]) if (cap_q[i] != IW'(i)) bad++;
    n_chk++; if (cap_q.size() != N || bad != 0) begin n_fail++; $display("FAIL basic_capture_order got_n=%0d bad=%0d exp_n=%0d", cap_q.size(), bad, N); end
    n_chk++; if (runs_total != N-1 || runs_bad != 0) begin n_fail++; $display("FAIL basic_clr_gap runs=%0d bad=%0d exp runs=%0d bad=0", runs_total, runs_bad, N-1); end
    n_chk++; if (req3 != 2) begin n_fail++; $display("FAIL basic_req3_cycles got=%0d exp=2", req3); end
  endtask

  task automatic test_ties_extremes();
    int l;
    set_lat1();
    for (int i = 0; i < 16; i++) scores[i] = 38'sd100;
    clear_obs(); run(l);
    n_chk++; if (class_id !== 4'd0) begin n_fail++; $display("FAIL tie_class_id got=%0d exp=0", class_id); end
    n_chk++; if (class_score !== 38'sd100) begin n_fail++; $display("FAIL tie_class_score got=%0d exp=100", class_score); end
    for (int i = 0; i < 16; i++) scores[i] = MINV;
    scores[9] = MINV + 38'sd1;
    clear_obs(); run(l);
    n_chk++; if (class_id !== 4'd9) begin n_fail++; $display("FAIL extreme_class_id got=%0d exp=9", class_id); end
    n_chk++; if (class_score !== MINV + 38'sd1) begin n_fail++; $display("FAIL extreme_class_score got=%0d exp=%0d", class_score, MINV + 38'sd1); end
  endtask

  task automatic test_latency();
    int l;
    set_lat1(); load_basic(); lat[3] = 5; clear_obs();
    run(l);
    n_chk++; if (l != 35) begin n_fail++; $display("FAIL latency_total got=%0d exp=35", l); end
    n_chk++; if (req3 != 6) begin n_fail++; $display("FAIL latency_req3_cycles got=%0d exp=6", req3); end
    n_chk++; if (sel_chg != 0) begin n_fail++; $display("FAIL latency_sel_stable changes=%0d exp=0", sel_chg); end
    n_chk++; if (class_id !== 4'd2 || class_score !== 38'sd17) begin n_fail++; $display("FAIL latency_result got=%0d/%0d exp=2/17", class_id, class_score); end
    set_lat1();
  endtask

  task automatic test_clear_handshake();
    int l, bad;
    set_lat1(); load_basic(); force_clr = 1'b1; clear_obs();
    run(l);
    force_clr = 1'b0;
    n_chk++; if (class_id !== 4'd2 || class_score !== 38'sd17) begin n_fail++; $display("FAIL clr_forced_result got=%0d/%0d exp=2/17", class_id, class_score); end
    bad = 0;
    foreach (cap_q[i]) if (cap_q[i] != IW'(i)) bad++;
    n_chk++; if (cap_q.size() != N || bad != 0) begin n_fail++; $display("FAIL clr_forced_idx_advance got_n=%0d bad=%0d exp_n=%0d", cap_q.size(), bad, N); end
    n_chk++; if (l != 31) begin n_fail++; $display("FAIL clr_forced_latency got=%0d exp=31", l); end
    n_chk++; if (runs_total != N-1 || runs_bad != 0) begin n_fail++; $display("FAIL clr_gap runs=%0d bad=%0d exp runs=%0d bad=0", runs_total, runs_bad, N-1); end
  endtask

  task automatic test_reset_mid();
    int n, l;
    set_lat1(); load_basic(); clear_obs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(fc_enable && fc_sel == 4'd4) && n < 200) begin @(negedge clk); n++; end
    n_chk++; if (!(fc_enable && fc_sel == 4'd4)) begin n_fail++; $display("FAIL rstmid_reach_class4 timeout sel=%0d", fc_sel); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_chk++; if (fc_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_fc_enable got=%b exp=0", fc_enable); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_chk++; if (class_id !== '0 || class_score !== '0) begin n_fail++; $display("FAIL rstmid_result got=%0d/%0d exp=0/0", class_id, class_score); end
    repeat (40) @(negedge clk);
    n_chk++; if (valid_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_valid got=%0d exp=0", valid_cnt); end
    clear_obs(); run(l);
    n_chk++; if (l != 31 || class_id !== 4'd2) begin n_fail++; $display("FAIL rstmid_rerun lat=%0d id=%0d exp 31/2", l, class_id); end
  endtask

  task automatic test_back_to_back();
    int v [N] = '{7, -1, 7, 50, 49, -50, 50, 3, 0, 1};
    int n, bad, l;
    set_lat1();
    for (int i = 0; i < N; i++) scores[i] = DW'(v[i]);
    clear_obs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while (!valid && n < 1000) begin
      start = (n == 5 || n == 12 || n == 20 || n == 29) ? 1'b1 : 1'b0;
      @(negedge clk); n++;
    end
    start = 1'b0;
    n_chk++; if (n != 31) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=31", n); end
    n_chk++; if (class_id !== 4'd3 || class_score !== 38'sd50) begin n_fail++; $display("FAIL b2b_result got=%0d/%0d exp=3/50", class_id, class_score); end
    repeat (10) @(negedge clk);
    n_chk++; if (valid_cnt != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_single_valid got=%0d busy=%b exp=1/0", valid_cnt, busy); end
    bad = 0;
    foreach (cap_q[i]) if (cap_q[i] != IW'(i)) bad++;
    n_chk++; if (cap_q.size() != N || bad != 0) begin n_fail++; $display("FAIL b2b_capture_order got_n=%0d bad=%0d exp_n=%0d", cap_q.size(), bad, N); end
    scores[8] = 38'sd51; clear_obs();
    run(l);
    n_chk++; if (l != 31 || class_id !== 4'd8 || class_score !== 38'sd51) begin n_fail++; $display("FAIL b2b_second_run lat=%0d id=%0d score=%0d exp 31/8/51", l, class_id, class_score); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; force_clr = 1'b0;
    test_reset();
    test_basic();
    test_ties_extremes();
    test_latency();
    test_clear_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
